register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor of the 32x32-bit register file for the RISC-V core.
- Configurable data width, register count and number of combinational read ports.
- Optional hardwired-zero register 0.
- Adds a per-register busy scoreboard: decode allocates a destination, writeback clears it, and read ports report operand hazards to the pipeline control.

Parameters:
- XLEN, 32, data width in bits (8..64).
- AW, 5, address width; register count = 2**AW.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1: register 0 reads as zero, ignores writes and allocations; 0: register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- regIn_in  in  XLEN  write data.
- regInAddr_in  in  AW  write address.
- regInWE_in  in  1  write enable.
- allocWE_in  in  1  scoreboard allocate strobe from decode.
- allocAddr_in  in  AW  register being allocated.
- regOutAddr_in  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW].
- regOut_out  out  NRD*XLEN  packed read data.
- regBusy_out  out  NRD  per port: addressed register has a pending writer.
- busyCnt_out  out  AW+1  number of busy registers.

Behaviour:
- Reset: rst low forces all registers to 0, all busy bits to 0 and busyCnt_out to 0 immediately, without waiting for a clock edge. Reset dominates any write or alloc in the same cycle. Reset asserted mid-operation discards pending allocations.
- Write: on rising edge with regInWE_in=1, reg[regInAddr_in] <= regIn_in. Latency to array is 1 cycle.
- Read: combinational, zero latency. Every port is independent. Any number of ports may address the same register.
- ZERO_REG=1, register 0:
  - Reads return 0 and regBusy_out is 0.
  - Writes are dropped and allocations are ignored.
- Scoreboard, evaluated per rising edge:
  - allocWE_in sets busy[allocAddr_in].
  - regInWE_in clears busy[regInAddr_in].
  - Same address with both strobes in the same cycle: alloc wins; the bit stays/becomes 1 because the new producer supersedes the old one. The data write still occurs.
  - Alloc of an already-busy register: bit remains 1, count unchanged.
  - Write to a non-busy register: permitted; bit stays 0.
- busyCnt_out is a registered popcount maintained incrementally. Per edge it changes by exactly -1, 0 or +1. Its range is 0..2**AW (0..2**AW-1 when ZERO_REG=1). It never wraps.
- regBusy_out[i] = busy[addr_i] is combinational, apart from the bypass qualification below.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - When regInWE_in=1 and regInAddr_in equals read address i (excluding register 0 under ZERO_REG), regOut_out port i returns regIn_in in the same cycle.
  - regBusy_out[i] is forced to 0 in that case unless allocWE_in targets the same address in that cycle.
  - Gives write-before-read semantics within one cycle.
- Undefined:
  - Read ports return the stored value, so new data is visible the cycle after the write edge.
  - regBusy_out reflects only the stored busy bits.

Test Plan:
- Reset/init: pulse rst low for 3 ns, with no clock edge during it. Then read registers 0, 1, 2, 31 on both ports -> all 0000_0000, regBusy_out=00, busyCnt_out=0. rst low mid-run after writes -> array and count clear asynchronously.
- Write/readback: write cccc_ffff@0, cccc_aaaa@1, cccc_bbbb@2, cccc_5555@3, ffff_ffff@31, then read back -> reg0 reads 0 (ZERO_REG=1), others return written values. Port 0 and port 1 on different addresses return independent data in the same cycle.
- Scoreboard: alloc 5 and 7 on consecutive edges -> busyCnt_out=2, and port reading 5 shows busy=1. Write 5 -> busy clears and count=1. Alloc 0 -> no change.
- Simultaneous alloc and write to register 7 -> data 1234_5678 stored, busy[7] stays 1, count unchanged. Alloc 9 plus write 7 in one cycle -> count unchanged, busy[9]=1, busy[7]=0.
- Bypass (REGFILE_BYPASS_EN defined): write dead_beef@4 while port 1 reads 4 -> regOut port 1=dead_beef in the same cycle and busy=0. Without the macro, the old value is returned until after the edge.
- Parameter sweep: XLEN=16, AW=3, NRD=4, ZERO_REG=0 -> reg0 writable. Alloc all 8 registers -> busyCnt_out=8 with no wrap. Four ports read distinct values concurrently.

Source files
------------

// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - Register file write, allocate and read bus
interface register_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [XLEN-1:0]     regIn_in;
    logic [AW-1:0]       regInAddr_in;
    logic                regInWE_in;
    logic                allocWE_in;
    logic [AW-1:0]       allocAddr_in;
    logic [NRD*AW-1:0]   regOutAddr_in;
    logic [NRD*XLEN-1:0] regOut_out;
    logic [NRD-1:0]      regBusy_out;
    logic [AW:0]         busyCnt_out;

    modport master (
        output regIn_in, regInAddr_in, regInWE_in, allocWE_in, allocAddr_in, regOutAddr_in,
        input  regOut_out, regBusy_out, busyCnt_out
    );

    modport slave (
        input  regIn_in, regInAddr_in, regInWE_in, allocWE_in, allocAddr_in, regOutAddr_in,
        output regOut_out, regBusy_out, busyCnt_out
    );
endinterface

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - Parametrised register file with busy scoreboard (option: REGFILE_BYPASS_EN)
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);
    localparam int          NREG    = 1 << AW;
    localparam bit          ZR      = (ZERO_REG != 0);
    localparam logic [AW:0] CNT_ONE = 1;

    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     busy;
    logic [AW:0]         busyCnt;
    logic [AW:0]         busyCntNext;
    logic                wrEff;
    logic                allocEff;
    logic                clrEff;
    logic                cntInc;
    logic                cntDec;
    logic [NRD*XLEN-1:0] rdData;
    logic [NRD-1:0]      rdBusy;

    // Qualify strobes (register 0 is inert when hardwired) and derive the count step
    always_comb begin
        wrEff       = bus.regInWE_in && !(ZR && bus.regInAddr_in == '0);
        allocEff    = bus.allocWE_in && !(ZR && bus.allocAddr_in == '0);
        // A same-address alloc supersedes the retiring producer, so no clear
        clrEff      = wrEff && !(allocEff && bus.allocAddr_in == bus.regInAddr_in);
        cntInc      = allocEff && !busy[bus.allocAddr_in];
        cntDec      = clrEff && busy[bus.regInAddr_in];
        busyCntNext = busyCnt;
        if (cntInc && !cntDec) begin
            busyCntNext = busyCnt + CNT_ONE;
        end else if (cntDec && !cntInc) begin
            busyCntNext = busyCnt - CNT_ONE;
        end
    end

    // Data array: asynchronous clear, single write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wrEff) begin
            regs[bus.regInAddr_in] <= bus.regIn_in;
        end
    end

    // Busy bits and incrementally maintained popcount
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            if (clrEff) begin
                busy[bus.regInAddr_in] <= 1'b0;
            end
            if (allocEff) begin
                busy[bus.allocAddr_in] <= 1'b1;
            end
            busyCnt <= busyCntNext;
        end
    end

    // Independent combinational read ports with optional write-port bypass
    always_comb begin
        logic [AW-1:0] a;
        logic          hitZero;
        logic          hitWr;
        a       = '0;
        hitZero = 1'b0;
        hitWr   = 1'b0;
        rdData  = '0;
        rdBusy  = '0;
        for (int i = 0; i < NRD; i++) begin
            a       = bus.regOutAddr_in[i*AW +: AW];
            hitZero = ZR && (a == '0);
            hitWr   = 1'b0;
`ifdef REGFILE_BYPASS_EN
            hitWr   = bus.regInWE_in && (bus.regInAddr_in == a) && !hitZero;
`endif
            if (hitZero) begin
                rdData[i*XLEN +: XLEN] = '0;
                rdBusy[i]              = 1'b0;
            end else if (hitWr) begin
                // Retiring write hides the hazard unless decode re-allocates now
                rdData[i*XLEN +: XLEN] = bus.regIn_in;
                rdBusy[i]              = (bus.allocWE_in && bus.allocAddr_in == a) ? busy[a] : 1'b0;
            end else begin
                rdData[i*XLEN +: XLEN] = regs[a];
                rdBusy[i]              = busy[a];
            end
        end
    end

    assign bus.regOut_out  = rdData;
    assign bus.regBusy_out = rdBusy;
    assign bus.busyCnt_out = busyCnt;
endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - Randomised self-checking bench for register_file_sb
module tb_register_file_sb;
    logic clk;
    logic rst;

    register_file_sb_if #(.XLEN(32), .AW(5), .NRD(2)) ifA ();
    register_file_sb_if #(.XLEN(16), .AW(3), .NRD(4)) ifB ();

    register_file_sb #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(1)) dutA (
        .clk(clk),
        .rst(rst),
        .bus(ifA)
    );

    register_file_sb #(.XLEN(16), .AW(3), .NRD(4), .ZERO_REG(0)) dutB (
        .clk(clk),
        .rst(rst),
        .bus(ifB)
    );

    int nChecks = 0;
    int nFail   = 0;

    logic [31:0] memA [32];
    bit          busyA [32];
    logic [15:0] memB [8];
    bit          busyB [8];

    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int r = 0; r < 32; r++) begin
            memA[r]  = '0;
            busyA[r] = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            memB[r]  = '0;
            busyB[r] = 1'b0;
        end
    endtask

    // One bus cycle on both DUTs; called 1 unit after a rising edge
    task automatic runCycle(input bit we, input int wa, input logic [31:0] wd,
                            input bit al, input int aa,
                            input int r0, input int r1, input int r2, input int r3);
        int          rs [4];
        int          cntA;
        int          cntB;
        logic [31:0] expD;
        bit          expBz;
        int          r;
        rs = '{r0, r1, r2, r3};
        ifA.regIn_in      = wd;
        ifA.regInAddr_in  = 5'(wa & 31);
        ifA.regInWE_in    = we;
        ifA.allocWE_in    = al;
        ifA.allocAddr_in  = 5'(aa & 31);
        ifA.regOutAddr_in = {5'(r1 & 31), 5'(r0 & 31)};
        ifB.regIn_in      = wd[15:0];
        ifB.regInAddr_in  = 3'(wa & 7);
        ifB.regInWE_in    = we;
        ifB.allocWE_in    = al;
        ifB.allocAddr_in  = 3'(aa & 7);
        ifB.regOutAddr_in = {3'(r3 & 7), 3'(r2 & 7), 3'(r1 & 7), 3'(r0 & 7)};
        #2;
        cntA = 0;
        cntB = 0;
        for (int k = 0; k < 32; k++) cntA += int'(busyA[k]);
        for (int k = 0; k < 8; k++)  cntB += int'(busyB[k]);
        for (int i = 0; i < 2; i++) begin
            r     = rs[i] & 31;
            expD  = (r == 0) ? 32'h0 : memA[r];
            expBz = (r == 0) ? 1'b0 : busyA[r];
`ifdef REGFILE_BYPASS_EN
            if (r != 0 && we && (wa & 31) == r) begin
                expD = wd;
                if (!(al && (aa & 31) == r)) expBz = 1'b0;
            end
`endif
            check($sformatf("A.data[%0d]@%0d", i, r), 64'(ifA.regOut_out[i*32 +: 32]), 64'(expD));
            check($sformatf("A.busy[%0d]@%0d", i, r), 64'(ifA.regBusy_out[i]), 64'(expBz));
        end
        for (int i = 0; i < 4; i++) begin
            r     = rs[i] & 7;
            expD  = 32'(memB[r]);
            expBz = busyB[r];
`ifdef REGFILE_BYPASS_EN
            if (we && (wa & 7) == r) begin
                expD = 32'(wd[15:0]);
                if (!(al && (aa & 7) == r)) expBz = 1'b0;
            end
`endif
            check($sformatf("B.data[%0d]@%0d", i, r), 64'(ifB.regOut_out[i*16 +: 16]), 64'(expD));
            check($sformatf("B.busy[%0d]@%0d", i, r), 64'(ifB.regBusy_out[i]), 64'(expBz));
        end
        check("A.busyCnt", 64'(ifA.busyCnt_out), 64'(cntA));
        check("B.busyCnt", 64'(ifB.busyCnt_out), 64'(cntB));
        @(posedge clk);
        // Reference: a write retires the producer, an alloc (applied after) installs a new one
        if (we && (wa & 31) != 0) begin
            memA[wa & 31]  = wd;
            busyA[wa & 31] = 1'b0;
        end
        if (al && (aa & 31) != 0) busyA[aa & 31] = 1'b1;
        if (we) begin
            memB[wa & 7]  = wd[15:0];
            busyB[wa & 7] = 1'b0;
        end
        if (al) busyB[aa & 7] = 1'b1;
        #1;
    endtask

    task automatic idle(input int r0, input int r1, input int r2, input int r3);
        runCycle(1'b0, 0, 32'h0, 1'b0, 0, r0, r1, r2, r3);
    endtask

    // Asynchronous reset between clock edges
    task automatic midReset();
        ifA.regInWE_in    = 1'b0;
        ifA.allocWE_in    = 1'b0;
        ifB.regInWE_in    = 1'b0;
        ifB.allocWE_in    = 1'b0;
        ifA.regOutAddr_in = {5'd2, 5'd1};
        ifB.regOutAddr_in = {3'd4, 3'd3, 3'd2, 3'd1};
        rst = 1'b0;
        #2;
        check("rst.A.data", 64'(ifA.regOut_out), 64'h0);
        check("rst.A.busy", 64'(ifA.regBusy_out), 64'h0);
        check("rst.A.cnt", 64'(ifA.busyCnt_out), 64'h0);
        check("rst.B.data", 64'(ifB.regOut_out), 64'h0);
        check("rst.B.cnt", 64'(ifB.busyCnt_out), 64'h0);
        clearModel();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clearModel();
        rst               = 1'b1;
        ifA.regIn_in      = '0;
        ifA.regInAddr_in  = '0;
        ifA.regInWE_in    = 1'b0;
        ifA.allocWE_in    = 1'b0;
        ifA.allocAddr_in  = '0;
        ifA.regOutAddr_in = {5'd1, 5'd0};
        ifB.regIn_in      = '0;
        ifB.regInAddr_in  = '0;
        ifB.regInWE_in    = 1'b0;
        ifB.allocWE_in    = 1'b0;
        ifB.allocAddr_in  = '0;
        ifB.regOutAddr_in = {3'd3, 3'd2, 3'd1, 3'd0};
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        #2;
        check("init.A.data01", 64'(ifA.regOut_out), 64'h0);
        check("init.A.busy", 64'(ifA.regBusy_out), 64'h0);
        check("init.A.cnt", 64'(ifA.busyCnt_out), 64'h0);
        check("init.B.data", 64'(ifB.regOut_out), 64'h0);
        ifA.regOutAddr_in = {5'd31, 5'd2};
        #1;
        check("init.A.data231", 64'(ifA.regOut_out), 64'h0);
        @(posedge clk);
        #1;

        runCycle(1'b1, 0,  32'hcccc_ffff, 1'b0, 0, 0, 1, 2, 3);
        runCycle(1'b1, 1,  32'hcccc_aaaa, 1'b0, 0, 0, 1, 2, 3);
        runCycle(1'b1, 2,  32'hcccc_bbbb, 1'b0, 0, 1, 2, 3, 0);
        runCycle(1'b1, 3,  32'hcccc_5555, 1'b0, 0, 2, 3, 0, 1);
        runCycle(1'b1, 31, 32'hffff_ffff, 1'b0, 0, 31, 3, 1, 2);
        idle(0, 1, 2, 3);
        idle(31, 2, 1, 0);
        idle(3, 31, 0, 2);

        runCycle(1'b0, 0, 32'h0, 1'b1, 5, 5, 7, 5, 7);
        runCycle(1'b0, 0, 32'h0, 1'b1, 7, 5, 7, 5, 7);
        idle(5, 7, 0, 1);
        runCycle(1'b1, 5, 32'h0000_0505, 1'b0, 0, 5, 7, 5, 7);
        idle(5, 7, 5, 7);
        runCycle(1'b0, 0, 32'h0, 1'b1, 0, 0, 7, 0, 5);
        idle(0, 7, 0, 5);

        runCycle(1'b1, 7, 32'h1234_5678, 1'b1, 7, 7, 9, 7, 1);
        idle(7, 9, 7, 1);
        runCycle(1'b1, 7, 32'h8765_4321, 1'b1, 9, 7, 9, 7, 1);
        idle(7, 9, 7, 1);

        runCycle(1'b1, 4, 32'hdead_beef, 1'b0, 0, 0, 4, 4, 4);
        runCycle(1'b1, 6, 32'h0bad_cafe, 1'b1, 6, 6, 6, 6, 6);
        idle(4, 6, 4, 6);

        midReset();
        idle(1, 2, 3, 4);

        runCycle(1'b1, 0, 32'h0000_a0a0, 1'b0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 5; k++) runCycle(1'b1, k, 32'h1111 * k, 1'b0, 0, 0, 1, 2, 3);
        idle(1, 2, 3, 4);
        idle(4, 3, 2, 0);
        for (int k = 0; k < 8; k++) runCycle(1'b0, 0, 32'h0, 1'b1, k, k, 0, 1, 2);
        idle(0, 3, 5, 7);
        runCycle(1'b0, 0, 32'h0, 1'b1, 3, 3, 4, 5, 6);
        idle(0, 1, 2, 3);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) midReset();
            runCycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        idle(0, 1, 2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
